// File: rtl/mor1kx_dbg_gpr_access.sv
// mor1kx_dbg_gpr_access
//
// SPR-bus initiator that lets a debug/host command port read and write the
// GPR file through the SPR GPR window (group 0, address[15:9] = 7'h2).
// A command moves 1..512 consecutive GPRs. Each transfer becomes one
// strobe/ack SPR transaction. Strobes are only issued while the CPU reports
// that it is stalled. Only one read is ever outstanding. A stuck responder
// is cut off by a timeout, and the host can abort a command at any time.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i                     1 = write burst, 0 = read burst
//   cmd_adr_i                    first GPR index {bank, reg}
//   cmd_len_i                    number of transfers minus one
//   wdat_valid_i/_ready_o/wdat_i write-data stream, one word per transfer
//   rdat_valid_o/_ready_i/rdat_o read-data stream, one word per transfer
//   done_o, err_o                registered end-of-command pulse and error flag
//   abort_i                      cancel the command in flight
//   stall_ack_i                  CPU pipeline stalled, bus access allowed
//   spr_bus_*_o                  SPR bus request (addr, stb, we, write data)
//   spr_gpr_ack_i, spr_gpr_dat_i GPR responder ack and read data
module mor1kx_dbg_gpr_access #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_we_i,
    input  logic [8:0]                      cmd_adr_i,
    input  logic [8:0]                      cmd_len_i,
    input  logic                            wdat_valid_i,
    output logic                            wdat_ready_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wdat_i,
    output logic                            rdat_valid_o,
    input  logic                            rdat_ready_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rdat_o,
    output logic                            done_o,
    output logic                            err_o,
    input  logic                            abort_i,
    input  logic                            stall_ack_i,
    output logic [15:0]                     spr_bus_addr_o,
    output logic                            spr_bus_stb_o,
    output logic                            spr_bus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic                            spr_gpr_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of unacked strobe cycles seen so far.
    // When one more unacked strobe cycle would make it reach TIMEOUT_CYCLES,
    // the command ends right away, so the counter never stores the limit.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFETCH,
        S_WRITE,
        S_READ,
        S_RHOLD
    } state_t;

    state_t                            state_q, state_d;
    logic [15:0]                       addr_q, addr_d;   // {7'h2, idx}; 0 after reset
    logic [8:0]                        rem_q, rem_d;
    logic [OPTION_OPERAND_WIDTH-1:0]   dat_q, dat_d;
    logic [OPTION_OPERAND_WIDTH-1:0]   rdat_q, rdat_d;
    logic [TW-1:0]                     tmo_q, tmo_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;

    logic bus_phase;
    logic stb;
    logic hit;

    // The strobe depends only on the state register and the stall
    // handshake. It never depends on ack, so there is no ack->stb loop.
    assign bus_phase = (state_q == S_WRITE) || (state_q == S_READ);
    assign stb       = bus_phase && stall_ack_i;
    assign hit       = stb && spr_gpr_ack_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if ((state_q != S_IDLE) && abort_i) begin
            // Abort wins over ack and timeout in the same cycle.
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_d  = {7'h2, cmd_adr_i};
                        rem_d   = cmd_len_i;
                        tmo_d   = '0;
                        state_d = cmd_we_i ? S_WFETCH : S_READ;
                    end
                end
                S_WFETCH: begin
                    if (wdat_valid_i) begin
                        dat_d   = wdat_i;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE, S_READ: begin
                    if (hit) begin
                        // An ack in the threshold cycle still counts as success.
                        tmo_d = '0;
                        if (state_q == S_READ) begin
                            rdat_d  = spr_gpr_dat_i;
                            state_d = S_RHOLD;
                        end else if (rem_q == 9'd0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rem_d       = rem_q - 9'd1;
                            addr_d[8:0] = addr_q[8:0] + 9'd1;
                            state_d     = S_WFETCH;
                        end
                    end else if (stb) begin
                        // While stalled, stb is low and the counter holds.
                        if (tmo_q == TMO_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TW'(1);
                        end
                    end
                end
                S_RHOLD: begin
                    if (rdat_ready_i) begin
                        if (rem_q == 9'd0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rem_d       = rem_q - 9'd1;
                            addr_d[8:0] = addr_q[8:0] + 9'd1;
                            state_d     = S_READ;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign wdat_ready_o   = (state_q == S_WFETCH);
    assign rdat_valid_o   = (state_q == S_RHOLD);
    assign rdat_o         = rdat_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign spr_bus_addr_o = addr_q;
    assign spr_bus_stb_o  = stb;
    assign spr_bus_we_o   = (state_q == S_WRITE);
    assign spr_bus_dat_o  = dat_q;

endmodule

// File: tb/tb_mor1kx_dbg_gpr_access.sv
module tb_mor1kx_dbg_gpr_access;

    localparam int W     = 32;
    localparam int TMO   = 8;
    localparam int NOACK = -1;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [8:0]    cmd_adr_i, cmd_len_i;
    logic          wdat_valid_i, wdat_ready_o;
    logic [W-1:0]  wdat_i;
    logic          rdat_valid_o, rdat_ready_i;
    logic [W-1:0]  rdat_o;
    logic          done_o, err_o, abort_i, stall_ack_i;
    logic [15:0]   spr_bus_addr_o;
    logic          spr_bus_stb_o, spr_bus_we_o;
    logic [W-1:0]  spr_bus_dat_o;
    logic          spr_gpr_ack_i;
    logic [W-1:0]  spr_gpr_dat_i;

    mor1kx_dbg_gpr_access #(
        .OPTION_OPERAND_WIDTH (W),
        .TIMEOUT_CYCLES       (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_len_i      (cmd_len_i),
        .wdat_valid_i   (wdat_valid_i),
        .wdat_ready_o   (wdat_ready_o),
        .wdat_i         (wdat_i),
        .rdat_valid_o   (rdat_valid_o),
        .rdat_ready_i   (rdat_ready_i),
        .rdat_o         (rdat_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .abort_i        (abort_i),
        .stall_ack_i    (stall_ack_i),
        .spr_bus_addr_o (spr_bus_addr_o),
        .spr_bus_stb_o  (spr_bus_stb_o),
        .spr_bus_we_o   (spr_bus_we_o),
        .spr_bus_dat_o  (spr_bus_dat_o),
        .spr_gpr_ack_i  (spr_gpr_ack_i),
        .spr_gpr_dat_i  (spr_gpr_dat_i)
    );

    function automatic logic [W-1:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- GPR responder (ack after resp_delay unacked strobes)
    logic [W-1:0] gpr_mem [512];
    logic         mem_init;
    int           resp_delay;
    int           stb_cnt;

    assign spr_gpr_ack_i = spr_bus_stb_o && (resp_delay >= 0) && (stb_cnt == resp_delay);
    assign spr_gpr_dat_i = gpr_mem[spr_bus_addr_o[8:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) gpr_mem[i] <= init_val(i);
        end else if (spr_bus_stb_o && spr_gpr_ack_i && spr_bus_we_o) begin
            gpr_mem[spr_bus_addr_o[8:0]] <= spr_bus_dat_o;
        end
        stb_cnt <= (spr_bus_stb_o && !spr_gpr_ack_i) ? stb_cnt + 1 : 0;
    end

    // ---------------- Monitor, sampled on the falling edge
    typedef struct packed {
        logic [15:0]  addr;
        logic         we;
        logic [W-1:0] dat;
    } bus_t;

    bus_t         bus_q [$];
    logic [W-1:0] rd_q  [$];
    int           stb_cycles = 0, wcnt = 0, done_cnt = 0;
    int           stall_viol = 0, proto_viol = 0, rd_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            rd_out = 0;
        end else begin
            if (spr_bus_stb_o) begin
                stb_cycles++;
                if (!stall_ack_i) stall_viol++;
                if (!spr_bus_we_o && rd_out != 0) proto_viol++;
                if (rdat_valid_o) proto_viol++;
            end
            if (spr_bus_stb_o && spr_gpr_ack_i) begin
                bus_q.push_back('{spr_bus_addr_o, spr_bus_we_o, spr_bus_dat_o});
                if (!spr_bus_we_o) rd_out++;
            end
            if (rdat_valid_o && rdat_ready_i) begin
                rd_q.push_back(rdat_o);
                rd_out--;
            end
            if (wdat_valid_i && wdat_ready_o) wcnt++;
            if (done_o) begin
                done_cnt++;
                rd_out = 0;
            end
        end
    end

    // ---------------- Checking
    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] mdl_gpr [512];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         we;
        logic [8:0] adr;
        logic [8:0] len;
        int         delay;
        bit         toggle;
        int         stall_at;
        int         stall_len;
        int         abort_rd;
        bit         exp_err;
        int         exp_bus;
        int         exp_rd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the done cycle.
    task automatic run_cmd(input int num, input vec_t v);
        int           bus0 = bus_q.size();
        int           rd0  = rd_q.size();
        int           stb0 = stb_cycles;
        int           w0   = wcnt;
        logic [W-1:0] wv [$];
        bit           fin = 1'b0, got_err = 1'b0, aborted = 1'b0;
        int           nb, nr, k;
        logic [8:0]   idx;

        for (int i = 0; i <= int'(v.len); i++) wv.push_back($urandom);
        resp_delay = v.delay;
        chk("cmd_ready_before_cmd", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_len_i   = v.len;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge clk);
            #1;
            cmd_valid_i = 1'b0;
            if (done_o) begin
                fin     = 1'b1;
                got_err = err_o;
            end else begin
                k            = wcnt - w0;
                wdat_valid_i = 1'b1;
                wdat_i       = (k <= int'(v.len)) ? wv[k] : '0;
                stall_ack_i  = !(v.stall_len > 0 && cyc >= v.stall_at &&
                                 cyc < v.stall_at + v.stall_len);
                abort_i      = 1'b0;
                rdat_ready_i = v.toggle ? (cyc % 2 == 1) : 1'b1;
                if (v.abort_rd >= 0 && !aborted && rdat_valid_o &&
                    (rd_q.size() - rd0) == v.abort_rd) begin
                    abort_i      = 1'b1;
                    rdat_ready_i = 1'b0;
                    aborted      = 1'b1;
                end
            end
        end
        wdat_valid_i = 1'b0;
        rdat_ready_i = 1'b0;
        abort_i      = 1'b0;
        stall_ack_i  = 1'b1;

        nb = bus_q.size() - bus0;
        nr = rd_q.size() - rd0;
        $display("cmd %0d: we=%0d adr=%03h len=%0d bus_xfers=%0d reads=%0d done=%0d err=%0d",
                 num, v.we, v.adr, v.len, nb, nr, fin, got_err);
        chk("done_seen", fin, 1);
        chk("err_flag", got_err, v.exp_err);
        chk("cmd_ready_at_done", cmd_ready_o, 1);
        chk("rdat_valid_at_done", rdat_valid_o, 0);
        chk("bus_xfer_count", nb, v.exp_bus);
        chk("read_accept_count", nr, v.exp_rd);
        for (int i = 0; i < nb && i < v.exp_bus; i++) begin
            idx = 9'(int'(v.adr) + i);
            chk("bus_addr", bus_q[bus0 + i].addr, {7'h2, idx});
            chk("bus_we", bus_q[bus0 + i].we, v.we);
            if (v.we) begin
                chk("bus_wdata", bus_q[bus0 + i].dat, wv[i]);
                mdl_gpr[idx] = wv[i];
            end
        end
        for (int i = 0; i < nr && i < v.exp_rd; i++) begin
            idx = 9'(int'(v.adr) + i);
            chk("read_data", rd_q[rd0 + i], mdl_gpr[idx]);
        end
        if (v.exp_err && v.abort_rd < 0) chk("timeout_stb_cycles", stb_cycles - stb0, TMO);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst          = 1'b1;
        mem_init     = 1'b1;
        resp_delay   = NOACK;
        cmd_valid_i  = 1'b0;
        cmd_we_i     = 1'b0;
        cmd_adr_i    = '0;
        cmd_len_i    = '0;
        wdat_valid_i = 1'b0;
        wdat_i       = '0;
        rdat_ready_i = 1'b0;
        abort_i      = 1'b0;
        stall_ack_i  = 1'b1;
        for (int i = 0; i < 512; i++) mdl_gpr[i] = init_val(i);

        // ---- Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_stb", spr_bus_stb_o, 0);
        chk("rst_we", spr_bus_we_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdat_valid", rdat_valid_o, 0);
        chk("rst_wdat_ready", wdat_ready_o, 0);
        chk("rst_addr", spr_bus_addr_o, 0);
        chk("rst_dat", spr_bus_dat_o, 0);
        chk("rst_rdat", rdat_o, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        // ---- Single write, minimum latency, ack in the strobe cycle
        resp_delay  = 0;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 9'h003; cmd_len_i = 9'd0;
        @(negedge clk);
        chk("w1_c0_stb", spr_bus_stb_o, 0);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; wdat_valid_i = 1'b1; wdat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("w1_c1_wdat_ready", wdat_ready_o, 1);
        chk("w1_c1_stb", spr_bus_stb_o, 0);
        @(posedge clk); #1;
        wdat_valid_i = 1'b0;
        @(negedge clk);
        chk("w1_c2_stb", spr_bus_stb_o, 1);
        chk("w1_c2_addr", spr_bus_addr_o, 16'h0403);
        chk("w1_c2_we", spr_bus_we_o, 1);
        chk("w1_c2_dat", spr_bus_dat_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_c3_done", done_o, 1);
        chk("w1_c3_err", err_o, 0);
        chk("w1_c3_stb", spr_bus_stb_o, 0);
        chk("w1_c3_cmd_ready", cmd_ready_o, 1);
        mdl_gpr[3] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_c4_done", done_o, 0);

        // ---- Single read, 1-cycle responder
        @(posedge clk); #1;
        resp_delay  = 1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h003; cmd_len_i = 9'd0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("r1_c1_stb", spr_bus_stb_o, 1);
        chk("r1_c1_we", spr_bus_we_o, 0);
        chk("r1_c1_addr", spr_bus_addr_o, 16'h0403);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r1_c2_stb", spr_bus_stb_o, 1);
        @(posedge clk); #1;
        rdat_ready_i = 1'b1;
        @(negedge clk);
        chk("r1_c3_stb", spr_bus_stb_o, 0);
        chk("r1_c3_rdat_valid", rdat_valid_o, 1);
        chk("r1_c3_rdat", rdat_o, mdl_gpr[3]);
        @(posedge clk); #1;
        rdat_ready_i = 1'b0;
        @(negedge clk);
        chk("r1_c4_done", done_o, 1);
        chk("r1_c4_err", err_o, 0);
        chk("r1_c4_rdat_valid", rdat_valid_o, 0);

        // ---- Reset while the strobe is high
        @(posedge clk); #1;
        resp_delay  = NOACK;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h007; cmd_len_i = 9'd2;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stb_before", spr_bus_stb_o, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stb_after", spr_bus_stb_o, 0);
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        chk("rst_mid_done", done_o, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_done_pulse", done_cnt - d0, 0);

        // ---- Table of commands: fixed corner cases, then random bursts
        //                we    adr     len  delay  tgl st_at st_len ab_rd err bus rd
        vecs[0] = '{1'b1, 9'h003, 9'd0, 0,     1'b0, 0, 0,  -1, 1'b0, 1, 0};
        vecs[1] = '{1'b0, 9'h1FE, 9'd3, 1,     1'b1, 0, 0,  -1, 1'b0, 4, 4};
        vecs[2] = '{1'b1, 9'h010, 9'd2, 1,     1'b0, 2, 50, -1, 1'b0, 3, 0};
        vecs[3] = '{1'b0, 9'h005, 9'd0, NOACK, 1'b0, 0, 0,  -1, 1'b1, 0, 0};
        vecs[4] = '{1'b0, 9'h040, 9'd3, 1,     1'b0, 0, 0,   1, 1'b1, 2, 1};
        vecs[5] = '{1'b0, 9'h020, 9'd0, TMO-1, 1'b0, 0, 0,  -1, 1'b0, 1, 1};
        vecs[6] = '{1'b0, 9'h021, 9'd0, TMO,   1'b0, 0, 0,  -1, 1'b1, 0, 0};
        vecs[7] = '{1'b0, 9'h010, 9'd2, 0,     1'b0, 0, 0,  -1, 1'b0, 3, 3};
        for (int i = 8; i < NVEC; i++) begin
            vecs[i].we        = $urandom_range(0, 1) == 1;
            vecs[i].adr       = 9'($urandom_range(504, 519));
            vecs[i].len       = 9'($urandom_range(0, 4));
            vecs[i].delay     = $urandom_range(0, 3);
            vecs[i].toggle    = $urandom_range(0, 1) == 1;
            vecs[i].stall_at  = 0;
            vecs[i].stall_len = 0;
            vecs[i].abort_rd  = -1;
            vecs[i].exp_err   = 1'b0;
            vecs[i].exp_bus   = int'(vecs[i].len) + 1;
            vecs[i].exp_rd    = vecs[i].we ? 0 : int'(vecs[i].len) + 1;
        end

        @(posedge clk); #1;
        for (int i = 0; i < NVEC; i++) run_cmd(i, vecs[i]);

        chk("stb_while_stalled", stall_viol, 0);
        chk("outstanding_read_rule", proto_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mor1kx_dbg_gpr_access.md
# mor1kx_dbg_gpr_access

SPR-bus initiator that gives a debug/host command port read and write access to the GPR file through the SPR GPR window (group 0, address bits [15:9] = 7'h2). It sits between the debug transport logic and the cappuccino SPR bus. It converts single or burst GPR commands into strobe/ack SPR transactions that the register file answers. It handles CPU-stall gating, read-data backpressure, burst address stepping, timeout and abort.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, SPR/GPR data width
- TIMEOUT_CYCLES, 256, strobe-asserted cycles without ack before abort; must be ≥1
- Counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  9  start GPR index {bank, reg}
- cmd_len_i  in  9  transfers minus one (1..512 transfers)
- wdat_valid_i / wdat_ready_o / wdat_i  in/out/in  1/1/OPTION_OPERAND_WIDTH  write-data stream
- rdat_valid_o / rdat_ready_i / rdat_o  out/in/out  1/1/OPTION_OPERAND_WIDTH  read-data stream
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  valid with done_o: 1 = timeout or abort
- abort_i  in  1  cancel current command
- stall_ack_i  in  1  CPU pipeline is stalled; access allowed
- spr_bus_addr_o  out  16  {7'h2, idx}
- spr_bus_stb_o / spr_bus_we_o  out  1 / 1
- spr_bus_dat_o  out  OPTION_OPERAND_WIDTH  write data
- spr_gpr_ack_i  in  1  responder ack
- spr_gpr_dat_i  in  OPTION_OPERAND_WIDTH  responder read data

## Operation
- States:
  - IDLE, WFETCH, WRITE, READ, RHOLD.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch we, idx=cmd_adr_i, rem=cmd_len_i, and clear the timeout counter.
  - Go to WFETCH if we, else READ.
- WFETCH:
  - wdat_ready_o=1.
  - On wdat_valid_i, latch wdat_i into dat_r and go to WRITE.
- WRITE / READ:
  - spr_bus_stb_o = stall_ack_i.
  - spr_bus_we_o = (state==WRITE).
  - addr/dat come from registers.
  - On stb&ack:
    - READ: capture spr_gpr_dat_i into rdat_o and go to RHOLD.
    - WRITE with rem==0: go to IDLE and pulse done_o (err_o=0).
    - WRITE otherwise: rem−1, idx+1, go to WFETCH.
- RHOLD:
  - rdat_valid_o=1.
  - On rdat_ready_i with rem==0: go to IDLE and pulse done_o.
  - Otherwise: rem−1, idx+1, go to READ.
  - Only one read is ever outstanding, so no read is issued while data is unaccepted.
- idx increments modulo 512 (0x1FF→0x000).
- Timeout:
  - The counter increments on each cycle with stb=1 and ack=0.
  - It holds while stall_ack_i=0.
  - It clears on each ack.
  - When it reaches TIMEOUT_CYCLES, go to IDLE with done_o=1, err_o=1. Remaining transfers are dropped.
  - Ack in the same cycle as the threshold: ack wins.
- abort_i:
  - In any non-IDLE state, go to IDLE next cycle with done_o=1, err_o=1. abort_i has priority over ack and timeout.
  - Ignored in IDLE.
- stall_ack_i low during WRITE/READ: stb drops, state and registers hold, and the access resumes when stall_ack_i returns.

## Timing
- Reset (rst sampled high at an edge): state IDLE; spr_bus_stb_o=0, spr_bus_we_o=0; done_o=0, err_o=0; rdat_valid_o=0, wdat_ready_o=0; cmd_ready_o=1; addr/dat/rdat_o=0.
- Reset mid-transaction: stb drops the next cycle. No done_o is issued.
- stb is decoded from the state register; there is no combinational path from ack to stb.
- The cycle after the ack edge, stb=0. At minimum, each SPR transaction is followed by one idle bus cycle.
- Single write, minimum latency:
  - Cmd accepted at edge 0, wdat at edge 1.
  - stb is high in cycle 2; ack arrives in cycle 2.
  - done_o is high in cycle 3.
- Single read with a 1-cycle responder:
  - stb is high in cycles 1–2, ack in cycle 2.
  - rdat_valid_o is high from cycle 3.
  - done_o is high in the cycle after rdat_ready_i is accepted.
- done_o and err_o are registered one-cycle pulses; cmd_ready_o=1 in that same cycle.

## Test plan
- Write 0xDEADBEEF to idx 3 with ack in the same cycle as stb → one stb cycle with addr 0x0403, we=1, dat 0xDEADBEEF; done_o=1, err_o=0.
- Burst read, cmd_adr=0x1FE, len=3, responder acks one cycle after stb, rdat_ready_i toggled 1/0 → addresses 0x05FE, 0x05FF, 0x0400, 0x0401 in order; never more than one access without its data accepted; done_o after the 4th accept.
- Hold stall_ack_i=0 for 50 cycles mid-write with TIMEOUT_CYCLES=16 → stb stays 0 and no timeout; the write completes after release.
- Read with no ack, TIMEOUT_CYCLES=8 → exactly 8 stb cycles, then done_o=1, err_o=1, IDLE, rdat_valid_o never asserted.
- abort_i during RHOLD of a 4-read burst → rdat_valid_o drops next cycle; done_o=1, err_o=1; a new command is then accepted normally.
- rst asserted with stb high → stb=0 and cmd_ready_o=1 after the edge; no done_o pulse.
